// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared constants and packed-port helper for the register file
package regfile_pkg;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NREAD  = 2;
    localparam int ZERO_REG   = 0;

    // LSB position of port `port` inside a packed multi-port vector
    function automatic int port_lsb(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// rtl/regfile_sb_if.sv - writeback, read, and issue signals of the register file
interface regfile_sb_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREAD  = 2
);
    logic                      we;
    logic [ADDR_W-1:0]         waddr;
    logic [DATA_W-1:0]         wdata;
    logic [NREAD*ADDR_W-1:0]   raddr;
    logic [NREAD*DATA_W-1:0]   rdata;
    logic [NREAD-1:0]          rbusy;
    logic                      iss_valid;
    logic [ADDR_W-1:0]         iss_addr;
    logic                      any_busy;

    modport master (
        output we, waddr, wdata, raddr, iss_valid, iss_addr,
        input  rdata, rbusy, any_busy
    );

    modport slave (
        input  we, waddr, wdata, raddr, iss_valid, iss_addr,
        output rdata, rbusy, any_busy
    );
endinterface

// File: rtl/regfile_scoreboard.sv
// rtl/regfile_scoreboard.sv - per-register write-pending bits with issue-over-writeback priority
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     set_en,
    input  logic [ADDR_W-1:0]        set_addr,
    input  logic                     clr_en,
    input  logic [ADDR_W-1:0]        clr_addr,
    output logic [(1<<ADDR_W)-1:0]   busy,
    output logic                     any_busy
);
    logic [(1<<ADDR_W)-1:0] busy_q;
    logic [(1<<ADDR_W)-1:0] busy_d;

    // Set is applied after clear so a new producer issuing as the old one retires keeps the bit
    always_comb begin
        busy_d = busy_q;
        if (clr_en) busy_d[clr_addr] = 1'b0;
        if (set_en) busy_d[set_addr] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    assign busy     = busy_q;
    assign any_busy = |busy_q;
endmodule

// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - multi-read-port register file with optional bypass and busy scoreboard
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int NREAD  = DEF_NREAD,
    parameter int BYPASS = 1
) (
    input  logic        clk,
    input  logic        rst,
    regfile_sb_if.slave bus
);
    localparam int                DEPTH     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    // Register 0 has no storage; reads of it are forced to zero below
    logic [DATA_W-1:0] mem [1:DEPTH-1];
    logic [DEPTH-1:0]  busy;
    logic              wr_en;
    logic              set_en;
    logic              any_busy;

    assign wr_en  = bus.we && (bus.waddr != ZERO_ADDR);
    assign set_en = bus.iss_valid && (bus.iss_addr != ZERO_ADDR);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) mem[i] <= '0;
        end else if (wr_en) begin
            mem[bus.waddr] <= bus.wdata;
        end
    end

    regfile_scoreboard #(.ADDR_W(ADDR_W)) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (set_en),
        .set_addr (bus.iss_addr),
        .clr_en   (wr_en),
        .clr_addr (bus.waddr),
        .busy     (busy),
        .any_busy (any_busy)
    );

    assign bus.any_busy = any_busy;

    for (genvar g = 0; g < NREAD; g++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic              hit;

        assign ra  = bus.raddr[port_lsb(g, ADDR_W) +: ADDR_W];
        // A forwarded value is by definition no longer pending
        assign hit = (BYPASS != 0) && wr_en && (bus.waddr == ra);

        assign bus.rdata[port_lsb(g, DATA_W) +: DATA_W] =
            (ra == ZERO_ADDR) ? '0 : (hit ? bus.wdata : mem[ra]);
        assign bus.rbusy[g] = (ra != ZERO_ADDR) && !hit && busy[ra];
    end
endmodule

// File: tb/tb_regfile_sb.sv
// tb/tb_regfile_sb.sv - directed bench driving a non-bypass and a bypass register file in lockstep
`timescale 1ns/1ps
module tb_regfile_sb;
    logic        clk = 1'b0;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr0, raddr1;
    logic        iss_valid;
    logic [4:0]  iss_addr;

    int n_cmp = 0;
    int n_err = 0;

    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus0 ();
    regfile_sb_if #(.DATA_W(32), .ADDR_W(5), .NREAD(2)) bus1 ();

    assign bus0.we = we;           assign bus1.we = we;
    assign bus0.waddr = waddr;     assign bus1.waddr = waddr;
    assign bus0.wdata = wdata;     assign bus1.wdata = wdata;
    assign bus0.raddr = {raddr1, raddr0};
    assign bus1.raddr = {raddr1, raddr0};
    assign bus0.iss_valid = iss_valid; assign bus1.iss_valid = iss_valid;
    assign bus0.iss_addr = iss_addr;   assign bus1.iss_addr = iss_addr;

    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(0)) dut0 (
        .clk (clk), .rst (rst), .bus (bus0)
    );
    regfile_sb #(.DATA_W(32), .ADDR_W(5), .NREAD(2), .BYPASS(1)) dut1 (
        .clk (clk), .rst (rst), .bus (bus1)
    );

    always #50 clk = ~clk;

    wire [31:0] d0_r0 = bus0.rdata[31:0];
    wire [31:0] d0_r1 = bus0.rdata[63:32];
    wire [31:0] d1_r0 = bus1.rdata[31:0];
    wire [31:0] d1_r1 = bus1.rdata[63:32];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        we = 1'b0; waddr = '0; wdata = '0;
        iss_valid = 1'b0; iss_addr = '0;
    endtask

    task automatic step();
        @(posedge clk);
        #5;
    endtask

    initial begin
        rst = 1'b1; raddr0 = 5'd5; raddr1 = 5'd9; idle();
        #1;
        check("in_reset_rdata0", d0_r0, 32'h0);
        check("in_reset_any_busy", {31'b0, bus1.any_busy}, 32'h0);
        repeat (2) step();
        rst = 1'b0;

        // Fill every register with random data and mark all busy (set beats same-address clear)
        for (int a = 1; a < 32; a++) begin
            we = 1'b1; waddr = 5'(a); wdata = $urandom;
            iss_valid = 1'b1; iss_addr = 5'(a);
            step();
        end
        idle();
        #1;
        check("filled_any_busy0", {31'b0, bus0.any_busy}, 32'h1);
        check("filled_any_busy1", {31'b0, bus1.any_busy}, 32'h1);

        // Asynchronous reset between edges clears everything before the next edge
        #2 rst = 1'b1;
        for (int a = 0; a < 32; a++) begin
            raddr0 = 5'(a); raddr1 = 5'(31 - a);
            #1;
            check("rst_d0_rdata0", d0_r0, 32'h0);
            check("rst_d1_rdata1", d1_r1, 32'h0);
            check("rst_d0_rbusy", {30'b0, bus0.rbusy}, 32'h0);
            check("rst_d1_rbusy", {30'b0, bus1.rbusy}, 32'h0);
        end
        check("rst_any_busy0", {31'b0, bus0.any_busy}, 32'h0);
        check("rst_any_busy1", {31'b0, bus1.any_busy}, 32'h0);

        // Write on an edge where rst is high is dropped
        we = 1'b1; waddr = 5'd6; wdata = 32'h55;
        step();
        rst = 1'b0; idle(); raddr0 = 5'd6;
        #1;
        check("wr_in_rst_d0", d0_r0, 32'h0);
        check("wr_in_rst_d1", d1_r0, 32'h0);

        // Register 0 is never stored nor forwarded
        we = 1'b1; waddr = 5'd0; wdata = 32'hDEADBEEF; raddr0 = 5'd0; raddr1 = 5'd0;
        #1;
        check("r0_bypass_d1", d1_r0, 32'h0);
        step();
        idle();
        #1;
        check("r0_read_d0", d0_r0, 32'h0);
        check("r0_read_d1", d1_r1, 32'h0);

        // Write latency: old value before the edge without bypass, new value after
        we = 1'b1; waddr = 5'd5; wdata = 32'h11111111;
        step();
        we = 1'b1; waddr = 5'd5; wdata = 32'h12345678; raddr0 = 5'd5; raddr1 = 5'd5;
        #1;
        check("wr5_pre_d0_p0", d0_r0, 32'h11111111);
        check("wr5_pre_d0_p1", d0_r1, 32'h11111111);
        check("wr5_pre_d1_p0", d1_r0, 32'h12345678);
        step();
        idle();
        #1;
        check("wr5_post_d0_p0", d0_r0, 32'h12345678);
        check("wr5_post_d0_p1", d0_r1, 32'h12345678);
        check("wr5_post_d1_p1", d1_r1, 32'h12345678);

        // Bypass hides a pending busy bit for the register being written back
        iss_valid = 1'b1; iss_addr = 5'd7;
        step();
        idle();
        we = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5; raddr0 = 5'd7;
        #1;
        check("byp7_d1_rdata", d1_r0, 32'hA5A5A5A5);
        check("byp7_d1_rbusy", {31'b0, bus1.rbusy[0]}, 32'h0);
        check("byp7_d0_rdata", d0_r0, 32'h0);
        check("byp7_d0_rbusy", {31'b0, bus0.rbusy[0]}, 32'h1);
        step();
        idle();
        #1;
        check("wb7_any_busy", {31'b0, bus0.any_busy}, 32'h0);

        // Issue r3: invisible in the issuing cycle, busy from the next
        iss_valid = 1'b1; iss_addr = 5'd3; raddr0 = 5'd3;
        #1;
        check("iss3_same_cycle", {31'b0, bus0.rbusy[0]}, 32'h0);
        step();
        idle();
        #1;
        check("iss3_rbusy", {31'b0, bus0.rbusy[0]}, 32'h1);
        check("iss3_any_busy", {31'b0, bus1.any_busy}, 32'h1);
        we = 1'b1; waddr = 5'd3; wdata = 32'h3;
        #1;
        check("wb3_d0_still_busy", {31'b0, bus0.rbusy[0]}, 32'h1);
        check("wb3_d1_forwarded", {31'b0, bus1.rbusy[0]}, 32'h0);
        step();
        idle();
        #1;
        check("wb3_rbusy", {31'b0, bus0.rbusy[0]}, 32'h0);
        check("wb3_any_busy", {31'b0, bus0.any_busy}, 32'h0);

        // Same-address issue and writeback: set wins
        iss_valid = 1'b1; iss_addr = 5'd9;
        step();
        iss_valid = 1'b1; iss_addr = 5'd9; we = 1'b1; waddr = 5'd9; wdata = 32'h9;
        step();
        idle(); raddr0 = 5'd9;
        #1;
        check("setclr9_d0", {31'b0, bus0.rbusy[0]}, 32'h1);
        check("setclr9_d1", {31'b0, bus1.rbusy[0]}, 32'h1);

        // Different-address issue and writeback both take effect
        iss_valid = 1'b1; iss_addr = 5'd4; we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        step();
        idle(); raddr0 = 5'd4; raddr1 = 5'd9;
        #1;
        check("set4_busy", {30'b0, bus0.rbusy}, 32'h1);
        check("clr9_busy", {30'b0, bus1.rbusy}, 32'h1);
        check("clr9_data", d0_r1, 32'h99);

        // Retire r4 while issuing r0; nothing should remain pending
        we = 1'b1; waddr = 5'd4; wdata = 32'h4; iss_valid = 1'b1; iss_addr = 5'd0;
        step();
        idle(); raddr0 = 5'd0;
        #1;
        check("iss0_any_busy0", {31'b0, bus0.any_busy}, 32'h0);
        check("iss0_any_busy1", {31'b0, bus1.any_busy}, 32'h0);
        check("iss0_rbusy", {31'b0, bus0.rbusy[0]}, 32'h0);

        // Reset mid-operation with r2 holding data and pending
        we = 1'b1; waddr = 5'd2; wdata = 32'hFF; iss_valid = 1'b1; iss_addr = 5'd2;
        step();
        idle(); raddr0 = 5'd2; raddr1 = 5'd2;
        #1;
        check("r2_before_rst", d0_r0, 32'hFF);
        check("r2_busy_before_rst", {31'b0, bus0.rbusy[0]}, 32'h1);
        #2 rst = 1'b1;
        #1;
        check("r2_rst_d0_rdata", d0_r0, 32'h0);
        check("r2_rst_d1_rdata", d1_r1, 32'h0);
        check("r2_rst_rbusy", {30'b0, bus0.rbusy}, 32'h0);
        we = 1'b1; waddr = 5'd2; wdata = 32'h77;
        step();
        rst = 1'b0; idle();
        #1;
        check("r2_wr_in_rst_d0", d0_r0, 32'h0);
        check("r2_wr_in_rst_d1", d1_r0, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-read-port general-purpose register file with an integrated write-pending scoreboard, for the pipelined CPU datapath. It holds 2^ADDR_W registers of DATA_W bits; register 0 reads as zero and is never writable. It has NREAD combinational read ports and one synchronous write port, with optional write-to-read bypass. A per-register busy bit is set when an instruction targeting that register issues and cleared on its writeback, so issue logic can detect RAW hazards.

## Interface
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; depth = 2^ADDR_W
- NREAD, 2, number of read ports (1..4)
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high
- we  input  1  writeback enable
- waddr  input  ADDR_W  writeback register address
- wdata  input  DATA_W  writeback data
- raddr  input  NREAD×ADDR_W  packed read addresses; port i = bits [i*ADDR_W +: ADDR_W]
- rdata  output  NREAD×DATA_W  packed read data, same packing
- rbusy  output  NREAD  busy flag of each read port's register
- iss_valid  input  1  instruction issuing with a destination register
- iss_addr  input  ADDR_W  destination of the issuing instruction
- any_busy  output  1  OR of all busy bits

## Operation
- Reset: all data registers are cleared to 0 and all busy bits to 0. During and immediately after reset, rdata = 0, rbusy = 0, and any_busy = 0.
- Write: on a clock edge with we=1 and waddr≠0, reg[waddr] ← wdata. A write with waddr=0 is ignored.
- Read, port i, combinational:
  - raddr_i=0 → rdata_i = 0.
  - Otherwise, if BYPASS=1, we=1, and waddr=raddr_i → rdata_i = wdata.
  - Otherwise rdata_i = reg[raddr_i].
- Busy set: on a clock edge with iss_valid=1 and iss_addr≠0, busy[iss_addr] ← 1.
- Busy clear: on a clock edge with we=1 and waddr≠0, busy[waddr] ← 0.
- Simultaneous set and clear on the same address: set wins and busy stays 1. This is the case where a new producer issues as the old one retires.
- Simultaneous set and clear on different addresses: both take effect.
- rbusy_i:
  - raddr_i=0 → 0.
  - BYPASS=1, we=1, waddr=raddr_i → 0, because the value is being forwarded.
  - Otherwise busy[raddr_i].
- rbusy does not reflect a same-cycle iss_valid; a same-cycle issue is seen only from the next cycle.
- Register 0: never busy, never stored. Its storage need not exist.
- Multiple read ports may carry the same address; each returns an identical result.

## Timing
- Read latency is 0 cycles; it is combinational from raddr, the stored state, and (when BYPASS=1) we/waddr/wdata.
- Write latency is 1 cycle:
  - With BYPASS=0, a value written at edge N is visible from edge N onward, i.e. in cycle N+1.
  - With BYPASS=1, it is also visible in the cycle before edge N.
- Busy update latency is 1 cycle after the issue or writeback edge.
- Reset mid-operation immediately and asynchronously clears all storage and busy bits. An in-flight write on the edge that coincides with rst is discarded.
- There is no handshake. Issue logic must stall while rbusy is asserted; the block does not enforce this.

## Structure
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W constants
  - ZERO_REG = 0
  - helper function for packed-port slicing
- Single module. The scoreboard is natural as sub-module regfile_scoreboard (busy vector, set/clear priority, any_busy), instantiated once. The data array and read muxes stay in the top module.

## Test plan
- Reset/zero:
  - Apply rst with random prior contents, read all addresses → rdata=0, rbusy=0, any_busy=0.
  - Write 0xDEADBEEF to addr 0, read addr 0 → 0.
- Write/readback, BYPASS=0:
  - Write 0x12345678 to r5 at edge N. Port 0 reads r5 in cycle N → old value; in cycle N+1 → 0x12345678.
  - Port 1 reading r5 concurrently gives the same result.
- Bypass, BYPASS=1:
  - we=1, waddr=7, wdata=0xA5A5A5A5 with raddr0=7 → rdata0=0xA5A5A5A5 and rbusy0=0 in the same cycle, even if busy[7]=1.
- Scoreboard:
  - Issue r3 at edge N → rbusy for r3 is 1 from cycle N+1 and any_busy=1.
  - Writeback r3 at edge M → rbusy=0 and any_busy=0 from cycle M+1.
- Simultaneous events:
  - Issue r9 and writeback r9 on the same edge → busy[9] stays 1.
  - Issue r4 and writeback r9 on the same edge → busy[4]=1, busy[9]=0.
  - Issue r0 → no busy bit is set.
- Async reset mid-operation:
  - Assert rst between edges while r2 holds 0xFF and busy[2]=1 → rdata(r2)=0 and rbusy=0 before the next edge.
  - A write on the edge where rst is high is not stored.
